vscale_hasti_sram_ws: RTL and testbench

- Parametrised AHB-Lite (HASTI) SRAM slave: a proper pipelined address/data-phase slave with configurable depth, base address and programmable wait states.
- Sits on the core's HASTI instruction or data bus as on-chip memory, replacing the fixed-size zero-latency SRAM model.
- Drives hready and hresp correctly, including stalls and an optional two-cycle ERROR response.

---
 rtl/vscale_hasti_sram_ws_pkg.sv | 25 ++
 rtl/vscale_hasti_sram_ws_if.sv | 29 ++
 rtl/vscale_hasti_bytemask.sv | 30 +++
 rtl/vscale_hasti_sram_ws.sv | 124 ++++++++++++
 tb/tb_vscale_hasti_sram_ws.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_hasti_sram_ws_pkg.sv
// HASTI SRAM slave: shared bus encodings and FSM states.
// Imported by the wait-state SRAM slave and its byte-lane helper.
package vscale_hasti_sram_ws_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/vscale_hasti_sram_ws_if.sv
// HASTI (AHB-Lite) bus bundle between a master and the SRAM slave.
// Fixed 32-bit address and data width.
interface vscale_hasti_sram_ws_if;

  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwrite, hsize, hburst,
    output hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst,
    input  hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/vscale_hasti_bytemask.sv
// HASTI byte-lane decoder: (hsize, haddr[1:0]) -> lane mask, misalign.
// Little-endian lanes; sizes above word decode as a full word.
module vscale_hasti_bytemask
  import vscale_hasti_sram_ws_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       misaligned
);

  // lane select and alignment check per transfer size
  always_comb begin
    mask       = 4'b1111;
    misaligned = 1'b0;
    unique case (1'b1)
      (hsize == HSIZE_BYTE): begin
        mask = 4'b0001 << addr_lo;
      end
      (hsize == HSIZE_HALF): begin
        mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/vscale_hasti_sram_ws.sv
// Pipelined HASTI SRAM slave with programmable wait states.
// VSCALE_HASTI_SRAM_ERR_EN adds range/alignment/size ERROR responses.
module vscale_hasti_sram_ws
  import vscale_hasti_sram_ws_pkg::*;
#(
  parameter int          NWORDS      = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic                   hclk,
  input logic                   hresetn,
  vscale_hasti_sram_ws_if.slave bus
);

  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [31:0] SPAN = 32'(4 * NWORDS);

  logic [31:0] mem [NWORDS];

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        write_q;
  logic [AW-1:0] idx_q;
  logic [3:0]  mask_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;

  logic        ready;
  logic        accept;
  logic        is_err;
  logic [31:0] off;
  logic [3:0]  lane;
  logic        misal;

  assign off = bus.haddr - BASE_ADDR;

  vscale_hasti_bytemask u_mask (
    .hsize      (bus.hsize),
    .addr_lo    (bus.haddr[1:0]),
    .mask       (lane),
    .misaligned (misal)
  );

  assign ready  = !(state == ST_WAIT || state == ST_ERR1);
  assign accept = ready && bus.htrans[1];

`ifdef VSCALE_HASTI_SRAM_ERR_EN
  assign is_err = (bus.haddr < BASE_ADDR) || (off >= SPAN)
                || misal || (bus.hsize > HSIZE_WORD);
  assign bus.hresp = (state == ST_ERR1 || state == ST_ERR2)
                   ? HRESP_ERROR : HRESP_OKAY;
`else
  assign is_err    = 1'b0;
  assign bus.hresp = HRESP_OKAY;
`endif

  assign bus.hready = ready;
  assign bus.hrdata = (state == ST_LAST && !write_q)
                    ? mem[idx_q] : 32'h0;

  // next state: wait countdown, error pair, or new address phase
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == ST_WAIT) begin
      cnt_n = cnt - 4'd1;
      if (cnt == 4'd1) state_n = ST_LAST;
    end else if (state == ST_ERR1) begin
      state_n = ST_ERR2;
    end else begin
      state_n = ST_IDLE;
      if (accept) begin
        if (is_err) begin
          state_n = ST_ERR1;
        end else if (WC == 4'd0) begin
          state_n = ST_LAST;
        end else begin
          state_n = ST_WAIT;
          cnt_n   = WC;
        end
      end
    end
  end

  // state, counter and address-phase capture
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= 4'd0;
      addr_q  <= 32'h0;
      size_q  <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        write_q <= bus.hwrite;
        idx_q   <= off[AW+1:2];
        mask_q  <= lane;
        addr_q  <= bus.haddr;
        size_q  <= bus.hsize;
      end
    end
  end

  // write commits on the LAST edge; a reset edge never writes
  always_ff @(posedge hclk) begin
    if (hresetn && state == ST_LAST && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  logic unused_sink;
  assign unused_sink = ^{bus.hburst, bus.hmastlock, bus.hprot,
                         bus.htrans[0], addr_q, size_q, off, misal};

endmodule

// File: tb/tb_vscale_hasti_sram_ws.sv
// Directed bench for vscale_hasti_sram_ws at 0 and 3 wait states.
// Error-response steps are built only with VSCALE_HASTI_SRAM_ERR_EN.
module tb_vscale_hasti_sram_ws;
  import vscale_hasti_sram_ws_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_err = 0;
  int n_chk = 0;
  logic [31:0] d;
  int l;

  always #5 clk = ~clk;

  vscale_hasti_sram_ws_if b0();
  vscale_hasti_sram_ws_if b3();

  vscale_hasti_sram_ws #(
    .NWORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
  ) u0 (.hclk(clk), .hresetn(rst_n), .bus(b0));

  vscale_hasti_sram_ws #(
    .NWORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)
  ) u3 (.hclk(clk), .hresetn(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ap0(input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [1:0] tr);
    b0.haddr = a; b0.hwrite = w; b0.hsize = sz; b0.htrans = tr;
  endtask

  task automatic ap3(input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [1:0] tr);
    b3.haddr = a; b3.hwrite = w; b3.hsize = sz; b3.htrans = tr;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd);
    ap0(a, 1'b1, sz, HTRANS_NONSEQ);
    step();
    b0.hwdata = wd;
    ap0(a, 1'b0, sz, HTRANS_IDLE);
    step();
  endtask

  task automatic rd0(input logic [31:0] a, output logic [31:0] rd);
    ap0(a, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    ap0(a, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    rd = b0.hrdata;
    step();
  endtask

  task automatic op3(input logic [31:0] a, input logic w,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output int lows);
    ap3(a, w, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    ap3(a, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    b3.hwdata = wd;
    lows = 0;
    while (b3.hready !== 1'b1 && lows < 20) begin
      lows++;
      step();
    end
    rd = b3.hrdata;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    ap3(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    b0.hwdata = 32'h0; b3.hwdata = 32'h0;
    b0.hburst = 3'd0; b0.hmastlock = 1'b0; b0.hprot = 4'd0;
    b3.hburst = 3'd0; b3.hmastlock = 1'b0; b3.hprot = 4'd0;
    #12 rst_n = 1'b1;

    chk("rst_hready0", 32'(b0.hready), 32'd1);
    chk("rst_hresp0", 32'(b0.hresp), 32'd0);
    chk("rst_hrdata0", b0.hrdata, 32'h0);
    chk("rst_hready3", 32'(b3.hready), 32'd1);
    chk("rst_hresp3", 32'(b3.hresp), 32'd0);
    step();

    // zero-wait write then read back-to-back
    ap0(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("b2b_wr_hready", 32'(b0.hready), 32'd1);
    b0.hwdata = 32'hDEADBEEF;
    ap0(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("b2b_rd_hready", 32'(b0.hready), 32'd1);
    chk("b2b_rd_data", b0.hrdata, 32'hDEADBEEF);
    ap0(32'h10, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    step();
    chk("b2b_idle_hrdata", b0.hrdata, 32'h0);

    // byte lanes
    wr0(32'h10, HSIZE_WORD, 32'h11223344);
    wr0(32'h13, HSIZE_BYTE, 32'hAA000000);
    rd0(32'h10, d);
    chk("byte3", d, 32'hAA223344);
    wr0(32'h10, HSIZE_HALF, 32'h00005566);
    rd0(32'h10, d);
    chk("half0", d, 32'hAA225566);
    wr0(32'h12, HSIZE_HALF, 32'h77880000);
    rd0(32'h10, d);
    chk("half1", d, 32'h77885566);
    wr0(32'h11, HSIZE_BYTE, 32'h0000CC00);
    rd0(32'h10, d);
    chk("byte1", d, 32'h7788CC66);

    // three wait states, pipelined second read held during WAIT
    op3(32'h0, 1'b1, 32'hCAFEF00D, d, l);
    chk("ws3_wr_lows", 32'(l), 32'd3);
    op3(32'h4, 1'b1, 32'h12345678, d, l);
    ap3(32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    ap3(32'h4, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    l = 0;
    while (b3.hready !== 1'b1 && l < 20) begin
      chk("ws3_wait_hresp", 32'(b3.hresp), 32'd0);
      l++;
      step();
    end
    chk("ws3_rd0_lows", 32'(l), 32'd3);
    chk("ws3_rd0_data", b3.hrdata, 32'hCAFEF00D);
    step();
    ap3(32'h4, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    l = 0;
    while (b3.hready !== 1'b1 && l < 20) begin
      l++;
      step();
    end
    chk("ws3_rd4_lows", 32'(l), 32'd3);
    chk("ws3_rd4_data", b3.hrdata, 32'h12345678);
    step();
    chk("ws3_idle_hready", 32'(b3.hready), 32'd1);
    chk("ws3_idle_hrdata", b3.hrdata, 32'h0);

    // reset during WAIT of a write aborts it
    op3(32'h20, 1'b1, 32'h0, d, l);
    ap3(32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    ap3(32'h20, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    b3.hwdata = 32'hFFFFFFFF;
    chk("abort_pre_hready", 32'(b3.hready), 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_hready", 32'(b3.hready), 32'd1);
    chk("abort_hresp", 32'(b3.hresp), 32'd0);
    #3 rst_n = 1'b1;
    step();
    step();
    op3(32'h20, 1'b0, 32'hFFFFFFFF, d, l);
    chk("abort_rd_data", d, 32'h0);
    chk("abort_rd_lows", 32'(l), 32'd3);

    // IDLE/BUSY interleaved with SEQ beats
    wr0(32'h0, HSIZE_WORD, 32'h01010101);
    wr0(32'h4, HSIZE_WORD, 32'h02020202);
    wr0(32'h8, HSIZE_WORD, 32'h03030303);
    b0.hwdata = 32'hFFFFFFFF;
    ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("seq_rd0", b0.hrdata, 32'h01010101);
    ap0(32'h4, 1'b1, HSIZE_WORD, HTRANS_BUSY);
    step();
    chk("busy_hready", 32'(b0.hready), 32'd1);
    chk("busy_hresp", 32'(b0.hresp), 32'd0);
    chk("busy_hrdata", b0.hrdata, 32'h0);
    ap0(32'h4, 1'b0, HSIZE_WORD, HTRANS_SEQ);
    step();
    chk("seq_rd4", b0.hrdata, 32'h02020202);
    ap0(32'h8, 1'b1, HSIZE_WORD, HTRANS_IDLE);
    step();
    chk("idle_hready", 32'(b0.hready), 32'd1);
    chk("idle_hrdata", b0.hrdata, 32'h0);
    ap0(32'h8, 1'b0, HSIZE_WORD, HTRANS_SEQ);
    step();
    chk("seq_rd8", b0.hrdata, 32'h03030303);
    ap0(32'h8, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    step();
    rd0(32'h4, d);
    chk("nospur_4", d, 32'h02020202);
    rd0(32'h8, d);
    chk("nospur_8", d, 32'h03030303);

`ifdef VSCALE_HASTI_SRAM_ERR_EN
    ap0(32'h1000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("oor_err1_hready", 32'(b0.hready), 32'd0);
    chk("oor_err1_hresp", 32'(b0.hresp), 32'd1);
    chk("oor_err1_hrdata", b0.hrdata, 32'h0);
    ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    step();
    chk("oor_err2_hready", 32'(b0.hready), 32'd1);
    chk("oor_err2_hresp", 32'(b0.hresp), 32'd1);
    step();
    chk("oor_done_hresp", 32'(b0.hresp), 32'd0);
    ap0(32'h2, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("mis_err1_hready", 32'(b0.hready), 32'd0);
    chk("mis_err1_hresp", 32'(b0.hresp), 32'd1);
    b0.hwdata = 32'hFFFFFFFF;
    ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    step();
    chk("mis_err2_hready", 32'(b0.hready), 32'd1);
    chk("mis_err2_hresp", 32'(b0.hresp), 32'd1);
    step();
    rd0(32'h0, d);
    chk("mis_mem_kept", d, 32'h01010101);
`else
    rd0(32'h1010, d);
    chk("wrap_rd", d, 32'h7788CC66);
    ap0(32'h2, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    chk("mis_hready", 32'(b0.hready), 32'd1);
    chk("mis_hresp", 32'(b0.hresp), 32'd0);
    b0.hwdata = 32'h0A0B0C0D;
    ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
    step();
    rd0(32'h0, d);
    chk("mis_word", d, 32'h0A0B0C0D);
    wr0(32'h8, 3'b011, 32'h0D0E0F10);
    rd0(32'h8, d);
    chk("big_size", d, 32'h0D0E0F10);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
